matmul2x2_seq_mac: RTL and testbench
====================================

// Module: matmul2x2_seq_mac
// PURPOSE
//   Sequential 2x2 matrix multiplier front end: C = A x B, unsigned W-bit elements.
//   Products a_ik*b_kj come from one shift-add multiplier, one multiplier bit per clock.
//   Each pair of 2W-bit products goes to the team's 8-bit ripple adder (eightbitadder).
//   Its (2W+1)-bit sum is registered into the result matrix.
//   Sits between the operand source and the matrix result consumer; start/busy/done handshake.
// PARAMETERS
//   W   4   element width; 4 is required with the 8-bit adder (2W = 8).
// PORTS
//   clk    in   1     single clock; all state updates on rising edge
//   rst    in   1     asynchronous, active-high reset
//   start  in   1     request; sampled only when busy=0
//   a_in   in   4W    A: [W-1:0]=a00, [2W-1:W]=a01, [3W-1:2W]=a10, [4W-1:3W]=a11
//   b_in   in   4W    B: same packing as a_in
//   c_out  out  8W+4  C: [8:0]=c00, [17:9]=c01, [26:18]=c10, [35:27]=c11 (W=4)
//   busy   out  1     high from the edge accepting start until the final write
//   done   out  1     one-cycle pulse; c_out is complete and valid
// BEHAVIOUR
//   Reset (async, immediate): state=IDLE, busy=0, done=0, c_out=0, all internal regs=0.
//   FSM states:
//   - IDLE: on start=1, edge E0 latches a_in/b_in into an internal copy.
//     Sets busy=1, idx=0, pass=0, bitcnt=0, and moves to MUL.
//   - MUL: one shift-add step per edge.
//     Multiplicand is a_i,pass; multiplier bit bitcnt is taken from b_pass,j.
//     After 4 edges: pass0 stores product p0 and continues in MUL with pass=1.
//     pass1 stores p1 and moves to ADD.
//   - ADD: one edge writes c[idx] = adder(p0,p1), a 9-bit result.
//     If idx<3: idx++, pass=0, back to MUL. If idx=3: busy=0, done=1, go to IDLE.
//   Element order: idx 0..3 = c00, c01, c10, c11 (i=idx[1], j=idx[0]).
//   Latency: 9 edges per element.
//   - c[idx] is written at edge E0+9*(idx+1).
//   - done is high only in the cycle after E0+36, then clears.
//   Arithmetic: unsigned only. Products fit 2W bits (max 225); sums fit 2W+1 bits (max 450).
//   No overflow is possible and no saturation is applied.
//   Operands: captured once at E0; a_in/b_in changes while busy have no effect.
//   start while busy=1 is ignored. It is not queued and does not restart the operation.
//   start in the done cycle: accepted, because state is IDLE.
//   - New E0 is that edge; done clears on it.
//   c_out stability:
//   - Holds its last value while idle.
//   - During a run, elements update one by one; the consumer samples only on done.
//   Reset mid-run: aborts immediately. Outputs go to reset values; no done pulse is produced.
// STRUCTURE
//   Shared package (matmul_pkg):
//   - W
//   - state localparams IDLE/MUL/ADD
//   - element index order and pack/unpack offset constants
//   Sub-module shift_add_mult4:
//   - Sequential W x W multiplier; step/clear inputs; 2W-bit product register.
//   - Shared by both passes.
//   The final sum uses one instance of the existing 8-bit ripple adder. Carry-out becomes bit 8.
//   Top level holds the FSM, idx/pass/bitcnt counters, operand copy and result registers.
// TESTING
//   1. A=[[1,2],[3,4]], B=[[5,6],[7,8]], start pulse -> done at E0+37.
//      Expect c00=19, c01=22, c10=43, c11=50.
//   2. All elements 15 -> every c = 450 (9'h1C2); bit 8 is set, so the adder carry is verified.
//   3. A=identity, B=[[9,4],[13,0]] -> C=B. A=0 -> C=0; busy still lasts 36 cycles.
//   4. start re-asserted at E0+10 with different a_in -> ignored; done at E0+37 with the first result.
//   5. rst asserted at E0+20 -> immediately busy=0, done=0, c_out=0.
//      A new start afterwards gives a correct result.
//   6. start held high through done -> back-to-back runs; second E0 is the done-cycle edge.
//      Both results are correct; done pulses are 37 cycles apart.

Source files
------------

// File: rtl/matmul2x2_seq_mac_pkg.sv
// Shared definitions for the sequential 2x2 matrix multiplier:
// element widths, FSM state encoding, element order and pack/unpack helpers.
package matmul2x2_seq_mac_pkg;

   // Element width; the downstream 8-bit ripple adder needs 2*W == 8.
   localparam int W         = 4;
   // Product width (W x W unsigned).
   localparam int PW        = 2 * W;
   // Result element width (sum of two products plus carry).
   localparam int SW        = 2 * W + 1;
   // Width of the multiplier bit counter.
   localparam int BCW       = 2;
   // Packed operand matrix width (four W-bit elements).
   localparam int OP_WIDTH  = 4 * W;
   // Packed result matrix width (four SW-bit elements).
   localparam int RES_WIDTH = 4 * SW;

   // Element index order: idx = {row, col}.
   localparam logic [1:0] IDX_C00 = 2'd0;
   localparam logic [1:0] IDX_C01 = 2'd1;
   localparam logic [1:0] IDX_C10 = 2'd2;
   localparam logic [1:0] IDX_C11 = 2'd3;

   // Control FSM states.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      ADD  = 2'd2
   } state_t;

   // LSB position of operand element (row, col) inside a packed operand matrix.
   function automatic int op_lsb(input logic row, input logic col);
      return W * int'({row, col});
   endfunction

   // LSB position of result element idx inside the packed result matrix.
   function automatic int res_lsb(input logic [1:0] idx);
      return SW * int'(idx);
   endfunction

   // Extract operand element (row, col) from a packed operand matrix.
   function automatic logic [W-1:0] get_elem(input logic [OP_WIDTH-1:0] m,
                                             input logic                row,
                                             input logic                col);
      return m[op_lsb(row, col) +: W];
   endfunction

endpackage

// File: rtl/matmul2x2_seq_mac_if.sv
// Handshake and data bus between the operand source (master) and the
// sequential 2x2 matrix multiplier (slave).
interface matmul2x2_seq_mac_if;
   import matmul2x2_seq_mac_pkg::*;

   logic                 start;
   logic [OP_WIDTH-1:0]  a_in;
   logic [OP_WIDTH-1:0]  b_in;
   logic [RES_WIDTH-1:0] c_out;
   logic                 busy;
   logic                 done;

   modport master (
      output start, a_in, b_in,
      input  c_out, busy, done
   );

   modport slave (
      input  start, a_in, b_in,
      output c_out, busy, done
   );

endinterface

// File: rtl/eightbitadder.sv
// Team 8-bit ripple-carry adder: sum = a + b + cin, carry out of bit 7 on cout.
module eightbitadder (
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       cin,
   output logic [7:0] sum,
   output logic       cout
);

   logic [8:0] carry_s;

   // Ripple the carry through eight full-adder cells.
   always_comb begin
      carry_s    = 9'd0;
      sum        = 8'd0;
      carry_s[0] = cin;
      for (int i = 0; i < 8; i++) begin
         sum[i]       = a[i] ^ b[i] ^ carry_s[i];
         carry_s[i+1] = (a[i] & b[i]) | (a[i] & carry_s[i]) | (b[i] & carry_s[i]);
      end
      cout = carry_s[8];
   end

endmodule

// File: rtl/matmul2x2_seq_mac_shift_add_mult4.sv
// Sequential W x W unsigned shift-add multiplier, one multiplier bit per step.
// A step with clear=1 starts a new product (the accumulator is loaded with
// the first partial product instead of being added to).
module shift_add_mult4
   import matmul2x2_seq_mac_pkg::*;
(
   input  logic           clk,
   input  logic           rst,
   input  logic           step,
   input  logic           clear,
   input  logic [W-1:0]   mcand,
   input  logic           mbit,
   input  logic [BCW-1:0] bit_idx,
   output logic [PW-1:0]  prod
);

   logic [PW-1:0] partial_s;
   logic [PW-1:0] acc_r;

   // Partial product for the current multiplier bit, aligned to its weight.
   always_comb begin
      partial_s = {PW{1'b0}};
      if (mbit) begin
         partial_s = {{(PW-W){1'b0}}, mcand} << bit_idx;
      end else begin
         partial_s = {PW{1'b0}};
      end
   end

   // Accumulate partial products; clear restarts the product.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_r <= {PW{1'b0}};
      end else if (step) begin
         if (clear) begin
            acc_r <= partial_s;
         end else begin
            acc_r <= acc_r + partial_s;
         end
      end else begin
         acc_r <= acc_r;
      end
   end

   assign prod = acc_r;

endmodule

// File: rtl/matmul2x2_seq_mac.sv
// Sequential 2x2 unsigned matrix multiplier C = A x B.
// Each result element c_ij = a_i0*b_0j + a_i1*b_1j takes 9 clocks:
// 4 shift-add steps per product (two passes) plus one add/write edge.
// Elements are produced in the order c00, c01, c10, c11.
module matmul2x2_seq_mac
   import matmul2x2_seq_mac_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   matmul2x2_seq_mac_if.slave  bus
);

   state_t               state_r;
   logic [OP_WIDTH-1:0]  a_r;
   logic [OP_WIDTH-1:0]  b_r;
   logic [1:0]           idx_r;
   logic                 pass_r;
   logic [BCW-1:0]       bitcnt_r;
   logic [PW-1:0]        p0_r;
   logic [RES_WIDTH-1:0] c_r;
   logic                 busy_r;
   logic                 done_r;

   logic                 mult_step_s;
   logic                 mult_clear_s;
   logic [W-1:0]         mcand_s;
   logic [W-1:0]         b_elem_s;
   logic                 mbit_s;
   logic [PW-1:0]        prod_s;
   logic [PW-1:0]        sum_s;
   logic                 cout_s;

   // Multiplier is stepped on every MUL edge; the first bit of each pass restarts it.
   always_comb begin
      mult_step_s  = 1'b0;
      mult_clear_s = 1'b0;
      if (state_r == MUL) begin
         mult_step_s  = 1'b1;
         mult_clear_s = (bitcnt_r == {BCW{1'b0}});
      end else begin
         mult_step_s  = 1'b0;
         mult_clear_s = 1'b0;
      end
   end

   // Operand selection: multiplicand a(i,pass), multiplier bit from b(pass,j).
   always_comb begin
      mcand_s  = get_elem(a_r, idx_r[1], pass_r);
      b_elem_s = get_elem(b_r, pass_r, idx_r[0]);
      mbit_s   = b_elem_s[bitcnt_r];
   end

   shift_add_mult4 u_mult (
      .clk     (clk),
      .rst     (rst),
      .step    (mult_step_s),
      .clear   (mult_clear_s),
      .mcand   (mcand_s),
      .mbit    (mbit_s),
      .bit_idx (bitcnt_r),
      .prod    (prod_s)
   );

   // p0 is held in p0_r; p1 is still in the multiplier register during ADD.
   eightbitadder u_add (
      .a    (p0_r),
      .b    (prod_s),
      .cin  (1'b0),
      .sum  (sum_s),
      .cout (cout_s)
   );

   // Control FSM with counters, operand copy and result registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r  <= IDLE;
         a_r      <= {OP_WIDTH{1'b0}};
         b_r      <= {OP_WIDTH{1'b0}};
         idx_r    <= 2'd0;
         pass_r   <= 1'b0;
         bitcnt_r <= {BCW{1'b0}};
         p0_r     <= {PW{1'b0}};
         c_r      <= {RES_WIDTH{1'b0}};
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               done_r <= 1'b0;
               if (bus.start) begin
                  a_r      <= bus.a_in;
                  b_r      <= bus.b_in;
                  idx_r    <= 2'd0;
                  pass_r   <= 1'b0;
                  bitcnt_r <= {BCW{1'b0}};
                  busy_r   <= 1'b1;
                  state_r  <= MUL;
               end else begin
                  busy_r   <= 1'b0;
                  state_r  <= IDLE;
               end
            end

            MUL: begin
               // On the first edge of pass 1 the multiplier still holds the
               // finished pass-0 product; keep it before it is overwritten.
               if (pass_r && (bitcnt_r == {BCW{1'b0}})) begin
                  p0_r <= prod_s;
               end else begin
                  p0_r <= p0_r;
               end
               if (bitcnt_r == BCW'(W - 1)) begin
                  bitcnt_r <= {BCW{1'b0}};
                  if (pass_r) begin
                     state_r <= ADD;
                  end else begin
                     pass_r  <= 1'b1;
                     state_r <= MUL;
                  end
               end else begin
                  bitcnt_r <= bitcnt_r + BCW'(1);
                  state_r  <= MUL;
               end
            end

            ADD: begin
               c_r[res_lsb(idx_r) +: SW] <= {cout_s, sum_s};
               pass_r <= 1'b0;
               if (idx_r == IDX_C11) begin
                  busy_r  <= 1'b0;
                  done_r  <= 1'b1;
                  state_r <= IDLE;
               end else begin
                  idx_r   <= idx_r + 2'd1;
                  state_r <= MUL;
               end
            end

            default: begin
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign bus.c_out = c_r;
   assign bus.busy  = busy_r;
   assign bus.done  = done_r;

endmodule

// File: tb/tb_matmul2x2_seq_mac.sv
// Directed testbench for matmul2x2_seq_mac with hand-computed expected matrices.
module tb_matmul2x2_seq_mac;
   import matmul2x2_seq_mac_pkg::*;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   matmul2x2_seq_mac_if bus ();

   matmul2x2_seq_mac dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pack four elements as [[e00,e01],[e10,e11]].
   function automatic logic [15:0] pack(input logic [3:0] e00, input logic [3:0] e01,
                                        input logic [3:0] e10, input logic [3:0] e11);
      return {e11, e10, e01, e00};
   endfunction

   // Present operands with start for one edge (the accepting edge E0).
   task automatic launch(input logic [15:0] a, input logic [15:0] b);
      bus.a_in  = a;
      bus.b_in  = b;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
   endtask

   // Step edges until done is seen or the limit expires; cycles counts edges after E0.
   task automatic wait_done(input int limit, output int cycles, output bit busy_held);
      cycles    = 0;
      busy_held = 1'b1;
      while (cycles < limit) begin
         @(posedge clk); #1;
         cycles++;
         if (bus.done === 1'b1) break;
         if (bus.busy !== 1'b1) busy_held = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.a_in  = 16'd0;
      bus.b_in  = 16'd0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
      checks++; if (bus.c_out !== 36'd0) begin errors++; $display("FAIL reset_c_out: got %h expected 0", bus.c_out); end
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", bus.busy); end
   endtask

   task automatic test_basic();
      int k;
      logic [35:0] exp_c;
      exp_c = {9'd50, 9'd43, 9'd22, 9'd19};
      launch(pack(4'd1, 4'd2, 4'd3, 4'd4), pack(4'd5, 4'd6, 4'd7, 4'd8));
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL basic_busy_e0: got %b expected 1", bus.busy); end
      k = 0;
      while (k < 60 && bus.done !== 1'b1) begin
         @(posedge clk); #1;
         k++;
         if (k == 8) begin
            checks++; if (bus.c_out !== 36'd0) begin errors++; $display("FAIL basic_c00_early: got %h expected 0", bus.c_out); end
         end
         if (k == 9) begin
            checks++; if (bus.c_out !== {27'd0, 9'd19}) begin errors++; $display("FAIL basic_c00_e9: got %h expected %h", bus.c_out, {27'd0, 9'd19}); end
         end
      end
      checks++; if (k !== 36) begin errors++; $display("FAIL basic_latency: got %0d edges expected 36", k); end
      checks++; if (bus.c_out !== exp_c) begin errors++; $display("FAIL basic_result: got %h expected %h", bus.c_out, exp_c); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL basic_busy_done: got %b expected 0", bus.busy); end
      @(posedge clk); #1;
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %b expected 0", bus.done); end
      checks++; if (bus.c_out !== exp_c) begin errors++; $display("FAIL basic_hold: got %h expected %h", bus.c_out, exp_c); end
   endtask

   task automatic test_max();
      int cyc;
      bit held;
      launch(pack(4'd15, 4'd15, 4'd15, 4'd15), pack(4'd15, 4'd15, 4'd15, 4'd15));
      wait_done(60, cyc, held);
      checks++; if (cyc !== 36) begin errors++; $display("FAIL max_latency: got %0d expected 36", cyc); end
      checks++; if (bus.c_out !== {4{9'h1C2}}) begin errors++; $display("FAIL max_result: got %h expected %h", bus.c_out, {4{9'h1C2}}); end
   endtask

   task automatic test_identity_zero();
      int cyc;
      bit held;
      launch(pack(4'd1, 4'd0, 4'd0, 4'd1), pack(4'd9, 4'd4, 4'd13, 4'd0));
      wait_done(60, cyc, held);
      checks++; if (bus.c_out !== {9'd0, 9'd13, 9'd4, 9'd9}) begin errors++; $display("FAIL ident_result: got %h expected %h", bus.c_out, {9'd0, 9'd13, 9'd4, 9'd9}); end
      launch(pack(4'd0, 4'd0, 4'd0, 4'd0), pack(4'd9, 4'd4, 4'd13, 4'd7));
      wait_done(60, cyc, held);
      checks++; if (cyc !== 36) begin errors++; $display("FAIL zero_latency: got %0d expected 36", cyc); end
      checks++; if (held !== 1'b1) begin errors++; $display("FAIL zero_busy_held: got %b expected 1", held); end
      checks++; if (bus.c_out !== 36'd0) begin errors++; $display("FAIL zero_result: got %h expected 0", bus.c_out); end
   endtask

   task automatic test_start_ignored();
      int k;
      bit held;
      held = 1'b1;
      launch(pack(4'd1, 4'd2, 4'd3, 4'd4), pack(4'd5, 4'd6, 4'd7, 4'd8));
      k = 0;
      while (k < 60 && bus.done !== 1'b1) begin
         @(posedge clk); #1;
         k++;
         if (k == 9) begin
            bus.start = 1'b1;
            bus.a_in  = pack(4'd15, 4'd15, 4'd15, 4'd15);
         end
         if (k == 11) bus.start = 1'b0;
         if (bus.done !== 1'b1 && bus.busy !== 1'b1) held = 1'b0;
      end
      checks++; if (k !== 36) begin errors++; $display("FAIL ignore_latency: got %0d expected 36", k); end
      checks++; if (held !== 1'b1) begin errors++; $display("FAIL ignore_busy_held: got %b expected 1", held); end
      checks++; if (bus.c_out !== {9'd50, 9'd43, 9'd22, 9'd19}) begin errors++; $display("FAIL ignore_result: got %h expected %h", bus.c_out, {9'd50, 9'd43, 9'd22, 9'd19}); end
   endtask

   task automatic test_reset_midrun();
      int cyc;
      int done_seen;
      bit held;
      launch(pack(4'd2, 4'd3, 4'd4, 4'd5), pack(4'd1, 4'd0, 4'd6, 4'd7));
      repeat (19) @(posedge clk);
      #1;
      checks++; if (bus.c_out !== {9'd50, 9'd43, 9'd21, 9'd20}) begin errors++; $display("FAIL abort_partial: got %h expected %h", bus.c_out, {9'd50, 9'd43, 9'd21, 9'd20}); end
      #3;
      rst = 1'b1;
      #1;
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", bus.busy); end
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL abort_done: got %b expected 0", bus.done); end
      checks++; if (bus.c_out !== 36'd0) begin errors++; $display("FAIL abort_c_out: got %h expected 0", bus.c_out); end
      @(posedge clk); #1;
      rst = 1'b0;
      done_seen = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (bus.done === 1'b1) done_seen++;
      end
      checks++; if (done_seen !== 0) begin errors++; $display("FAIL abort_no_done: got %0d pulses expected 0", done_seen); end
      launch(pack(4'd2, 4'd3, 4'd4, 4'd5), pack(4'd1, 4'd0, 4'd6, 4'd7));
      wait_done(60, cyc, held);
      checks++; if (cyc !== 36) begin errors++; $display("FAIL rerun_latency: got %0d expected 36", cyc); end
      checks++; if (bus.c_out !== {9'd35, 9'd34, 9'd21, 9'd20}) begin errors++; $display("FAIL rerun_result: got %h expected %h", bus.c_out, {9'd35, 9'd34, 9'd21, 9'd20}); end
   endtask

   task automatic test_back_to_back();
      int cyc1;
      int cyc2;
      bit held;
      bus.a_in  = pack(4'd1, 4'd2, 4'd3, 4'd4);
      bus.b_in  = pack(4'd5, 4'd6, 4'd7, 4'd8);
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.a_in  = pack(4'd1, 4'd0, 4'd0, 4'd1);
      bus.b_in  = pack(4'd9, 4'd4, 4'd13, 4'd0);
      wait_done(60, cyc1, held);
      checks++; if (cyc1 !== 36) begin errors++; $display("FAIL b2b_first_latency: got %0d expected 36", cyc1); end
      checks++; if (bus.c_out !== {9'd50, 9'd43, 9'd22, 9'd19}) begin errors++; $display("FAIL b2b_first_result: got %h expected %h", bus.c_out, {9'd50, 9'd43, 9'd22, 9'd19}); end
      @(posedge clk); #1;
      bus.start = 1'b0;
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL b2b_done_clear: got %b expected 0", bus.done); end
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_second_busy: got %b expected 1", bus.busy); end
      wait_done(60, cyc2, held);
      checks++; if ((cyc2 + 1) !== 37) begin errors++; $display("FAIL b2b_done_spacing: got %0d expected 37", cyc2 + 1); end
      checks++; if (bus.c_out !== {9'd0, 9'd13, 9'd4, 9'd9}) begin errors++; $display("FAIL b2b_second_result: got %h expected %h", bus.c_out, {9'd0, 9'd13, 9'd4, 9'd9}); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_basic();
      test_max();
      test_identity_zero();
      test_start_ignored();
      test_reset_midrun();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

endmodule
